// File: rtl/up_count_seq.sv
// Sequencing controller for the 12-bit enable-driven up counter: issues en pulses
// at a programmable rate, counts them per round, and runs one-shot or auto-repeat.
module up_count_seq #(
  parameter int unsigned CNT_W = 12,
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [PRE_W-1:0] prescale,
  input  logic [CNT_W-1:0] target,
  input  logic             one_shot,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t             state_q;
  logic [PRE_W-1:0]   pre_cnt_q;
  logic [PRE_W-1:0]   prescale_q;
  logic [CNT_W-1:0]   target_q;
  logic               one_shot_q;
  logic               en_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   pulses_q;

  logic [CNT_W-1:0]   round_base_c;
  logic [CNT_W-1:0]   pulses_d;
  logic               pulse_due_c;
  logic               last_c;

  // A count sitting at target means the previous round just closed; the next round restarts from zero.
  always_comb begin
    round_base_c = (pulses_q == target_q) ? '0 : pulses_q;
    pulses_d     = round_base_c + CNT_W'(1);
    pulse_due_c  = (pre_cnt_q == prescale_q);
    last_c       = (pulses_d == target_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      prescale_q <= '0;
      target_q   <= '0;
      one_shot_q <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pulses_q   <= '0;
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          pre_cnt_q <= '0;
          pulses_q  <= '0;
          busy_q    <= 1'b0;
          if (start && !stop && (target != '0)) begin
            state_q    <= S_RUN;
            prescale_q <= prescale;
            target_q   <= target;
            one_shot_q <= one_shot;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_q <= S_PAUSE;
          end else if (pulse_due_c) begin
            en_q      <= 1'b1;
            pre_cnt_q <= '0;
            pulses_q  <= pulses_d;
            if (last_c) begin
              done_q <= 1'b1;
              // busy and pulses are cleared by IDLE on the following edge.
              if (one_shot_q) state_q <= S_IDLE;
            end
          end else begin
            pre_cnt_q <= pre_cnt_q + PRE_W'(1);
            pulses_q  <= round_base_c;
          end
        end
        S_PAUSE: begin
          if (stop) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            pulses_q  <= '0;
            pre_cnt_q <= '0;
          end else if (start) begin
            state_q <= S_RUN;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign en     = en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign pulses = pulses_q;

endmodule

// File: tb/tb_up_count_seq.sv
// Directed bench for up_count_seq: table of per-edge vectors plus a long
// 4095-pulse one-shot sequence checked by counting.
module tb_up_count_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [7:0]  prescale;
  logic [11:0] target;
  logic        one_shot;
  logic        en;
  logic        busy;
  logic        done;
  logic [11:0] pulses;

  int total;
  int bad;

  up_count_seq #(.CNT_W(12), .PRE_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .prescale (prescale),
    .target   (target),
    .one_shot (one_shot),
    .en       (en),
    .busy     (busy),
    .done     (done),
    .pulses   (pulses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic        stop;
    logic [7:0]  pre;
    logic [11:0] tgt;
    logic        os;
    logic        en;
    logic        busy;
    logic        done;
    logic [11:0] pul;
    int          tag;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic s, input logic p,
                              input logic [7:0] pre, input logic [11:0] tgt, input logic os,
                              input logic e, input logic b, input logic d,
                              input logic [11:0] pul, input int tag);
    vec_t v;
    v.rst = r; v.start = s; v.stop = p; v.pre = pre; v.tgt = tgt; v.os = os;
    v.en = e; v.busy = b; v.done = d; v.pul = pul; v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic fill();
    // 1: reset mid-run
    add(1, 0, 0, 8'd0, 12'd10, 0, 0, 0, 0, 12'd0, 1);
    add(0, 1, 0, 8'd0, 12'd10, 0, 0, 1, 0, 12'd0, 1);
    for (int k = 1; k <= 3; k++) add(0, 0, 0, 8'd0, 12'd10, 0, 1, 1, 0, 12'(k), 1);
    for (int k = 0; k < 3; k++)  add(1, 0, 0, 8'd0, 12'd10, 0, 0, 0, 0, 12'd0, 1);
    for (int k = 0; k < 2; k++)  add(0, 0, 0, 8'd0, 12'd10, 0, 0, 0, 0, 12'd0, 1);
    // 2: prescale=3, target=4, one-shot
    add(0, 1, 0, 8'd3, 12'd4, 1, 0, 1, 0, 12'd0, 2);
    for (int k = 1; k <= 16; k++)
      add(0, 0, 0, 8'd3, 12'd4, 1, (k % 4) == 0, 1, k == 16, 12'(k / 4), 2);
    add(0, 0, 0, 8'd3, 12'd4, 1, 0, 0, 0, 12'd0, 2);
    // 3: prescale=0, target=5, auto-repeat for three rounds, then pause and abort
    add(0, 1, 0, 8'd0, 12'd5, 0, 0, 1, 0, 12'd0, 3);
    for (int k = 1; k <= 15; k++)
      add(0, 0, 0, 8'd0, 12'd5, 0, 1, 1, (k % 5) == 0, 12'(((k - 1) % 5) + 1), 3);
    add(0, 0, 1, 8'd0, 12'd5, 0, 0, 1, 0, 12'd5, 3);
    add(0, 0, 1, 8'd0, 12'd5, 0, 0, 0, 0, 12'd0, 3);
    add(0, 0, 0, 8'd0, 12'd5, 0, 0, 0, 0, 12'd0, 3);
    // 4: prescale=4, target=3, pause before the 2nd en, resume 5 cycles later
    add(0, 1, 0, 8'd4, 12'd3, 1, 0, 1, 0, 12'd0, 4);
    for (int k = 1; k <= 22; k++) begin
      logic [11:0] p;
      if (k < 5)       p = 12'd0;
      else if (k < 16) p = 12'd1;
      else if (k < 21) p = 12'd2;
      else if (k == 21) p = 12'd3;
      else             p = 12'd0;
      add(0, k == 14, k == 9, 8'd4, 12'd3, 1, (k == 5) || (k == 16) || (k == 21),
          k < 22, k == 21, p, 4);
    end
    // 5: start+stop in IDLE, then in RUN, then stop in PAUSE
    add(0, 1, 1, 8'd1, 12'd2, 1, 0, 0, 0, 12'd0, 5);
    add(0, 0, 0, 8'd1, 12'd2, 1, 0, 0, 0, 12'd0, 5);
    add(0, 1, 0, 8'd1, 12'd2, 1, 0, 1, 0, 12'd0, 5);
    add(0, 1, 1, 8'd1, 12'd2, 1, 0, 1, 0, 12'd0, 5);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 8'd1, 12'd2, 1, 0, 1, 0, 12'd0, 5);
    add(0, 1, 1, 8'd1, 12'd2, 1, 0, 0, 0, 12'd0, 5);
    add(0, 0, 0, 8'd1, 12'd2, 1, 0, 0, 0, 12'd0, 5);
    // 6a: target=0 start is ignored
    for (int k = 0; k < 3; k++) add(0, 1, 0, 8'd0, 12'd0, 1, 0, 0, 0, 12'd0, 6);
  endtask

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got en/busy/done/pulses=%b/%b/%b/%0d want %b/%b/%b/%0d",
               name, act[14], act[13], act[12], act[11:0], exp[14], exp[13], exp[12], exp[11:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    int en_cnt;
    int done_cnt;
    int pul_at_done;
    bit finished;
    total = 0;
    bad = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    prescale = '0; target = '0; one_shot = 1'b0;
    fill();
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
      prescale = vecs[i].pre; target = vecs[i].tgt; one_shot = vecs[i].os;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_t%0d", i, vecs[i].tag), {en, busy, done, pulses},
            {vecs[i].en, vecs[i].busy, vecs[i].done, vecs[i].pul});
    end

    // 6b: full-width one-shot round, prescale=0
    rst = 1'b0; start = 1'b1; stop = 1'b0;
    prescale = 8'd0; target = 12'd4095; one_shot = 1'b1;
    @(posedge clk);
    #1;
    check("max_start", {en, busy, done, pulses}, {1'b0, 1'b1, 1'b0, 12'd0});
    start = 1'b0;
    en_cnt = 0; done_cnt = 0; pul_at_done = -1; finished = 1'b0;
    for (int k = 0; k < 5000 && !finished; k++) begin
      @(posedge clk);
      #1;
      if (en) en_cnt++;
      if (done) begin
        done_cnt++;
        pul_at_done = int'(pulses);
      end
      if (!busy) finished = 1'b1;
    end
    check_int("max_finished", int'(finished), 1);
    check_int("max_en_count", en_cnt, 4095);
    check_int("max_done_count", done_cnt, 1);
    check_int("max_pulses_at_done", pul_at_done, 4095);
    check("max_idle", {en, busy, done, pulses}, {1'b0, 1'b0, 1'b0, 12'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
